// File: rtl/tspp_fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-memory reads and fills the
// fetch/execute latch under a valid/stall handshake. Branch and jump redirects
// from execute kill any wrong-path fetch, including one still on the bus.
//
//  state  | meaning
//  -------+------------------------------------------------------------------
//  FETCH  | read request at pc; completed data goes to the latch or the skid
//  HOLD   | fetched word parked in skid while execute stalls; bus idle
//  SQUASH | wrong-path read still in flight; wait it out, then jump to target
module tspp_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter int          ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    output logic              imem_ren,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_busy,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fe_valid,
    output logic [31:0]       fe_instr,
    output logic [ADDR_W-1:0] fe_pc,
    output logic [ADDR_W-1:0] fe_pc4
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic              fe_valid_q, fe_valid_d;
    logic [31:0]       fe_instr_q, fe_instr_d;
    logic [ADDR_W-1:0] fe_pc_q, fe_pc_d;

    logic              accept;
    logic [ADDR_W-1:0] redir_al;
    logic [ADDR_W-1:0] pc_inc;

    // The latch can take a new word when empty or when execute drains it now.
    assign accept   = !fe_valid_q || !stall;
    assign redir_al = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign pc_inc   = pc_q + ADDR_W'(4);

    // The address stays at pc even in SQUASH so a pending read never changes.
    assign imem_ren  = (state_q != HOLD);
    assign imem_addr = pc_q;
    assign fe_valid  = fe_valid_q;
    assign fe_instr  = fe_instr_q;
    assign fe_pc     = fe_pc_q;
    assign fe_pc4    = fe_pc_q + ADDR_W'(4);

    // Next-state and datapath decisions; redirect always wins.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        fe_valid_d   = fe_valid_q;
        fe_instr_d   = fe_instr_q;
        fe_pc_d      = fe_pc_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    fe_valid_d = 1'b0;
                    if (imem_busy) begin
                        target_d = redir_al;
                        state_d  = SQUASH;
                    end else begin
                        pc_d = redir_al;
                    end
                end else if (!imem_busy) begin
                    pc_d = pc_inc;
                    if (accept) begin
                        fe_valid_d = 1'b1;
                        fe_instr_d = imem_rdata;
                        fe_pc_d    = pc_q;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = HOLD;
                    end
                end else if (accept) begin
                    fe_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d       = redir_al;
                    fe_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (!stall) begin
                    fe_instr_d = skid_instr_q;
                    fe_pc_d    = skid_pc_q;
                    fe_valid_d = 1'b1;
                    state_d    = FETCH;
                end
            end
            SQUASH: begin
                fe_valid_d = 1'b0;
                if (!imem_busy) begin
                    pc_d    = redirect ? redir_al : target_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    target_d = redir_al;
                end
            end
            default: begin
                state_d    = FETCH;
                fe_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight read.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC[ADDR_W-1:0];
            target_q     <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            fe_valid_q   <= 1'b0;
            fe_instr_q   <= '0;
            fe_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            fe_valid_q   <= fe_valid_d;
            fe_instr_q   <= fe_instr_d;
            fe_pc_q      <= fe_pc_d;
        end
    end

endmodule

// File: doc/tspp_fetch_stage.md
Name: tspp_fetch_stage

Overview:
Fetch stage of the two-stage pipeline. It owns the PC, issues instruction reads on the instruction memory bus, and presents fetched instructions to the execute stage through the fetch/execute latch, using a valid/stall handshake. It absorbs memory wait states, execute backpressure and branch/jump redirects, discarding wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0200, PC value loaded on reset
ADDR_W, 32, PC and bus address width (fixed at 32 for RV32I)

Ports:
CLK  in  1  clock; all state updates on rising edge
nRST  in  1  asynchronous active-low reset
imem_ren  out  1  instruction read request; combinational from state
imem_addr  out  32  read address, word-aligned
imem_busy  in  1  high = transaction not complete; low while imem_ren=1 = imem_rdata valid this cycle
imem_rdata  in  32  instruction word
stall  in  1  execute cannot accept the latch contents this cycle
redirect  in  1  taken branch/jump/trap from execute; overrides all else
redirect_pc  in  32  redirect target; bits [1:0] ignored, forced to 00
fe_valid  out  1  latch holds a valid instruction
fe_instr  out  32  latched instruction
fe_pc  out  32  PC of fe_instr
fe_pc4  out  32  fe_pc+4, combinational

Behaviour:
- Reset (async, any state, including a transaction in flight): pc=RESET_PC, state=FETCH, fe_valid=0, fe_instr=0, fe_pc=0, skid regs=0. The in-flight bus transaction is abandoned. imem_ren=1 in the first cycle after nRST rises.
- Latch accept condition: accept = !fe_valid || !stall. Execute consumes the latch on any cycle with fe_valid && !stall. While fe_valid && stall, fe_* are held bit-stable.
- States: FETCH, HOLD, SQUASH.
- FETCH: imem_ren=1, imem_addr=pc.
  - redirect && imem_busy: target_r<=redirect_pc, go to SQUASH, fe_valid<=0.
  - redirect && !imem_busy: drop rdata, pc<=redirect_pc, fe_valid<=0, stay in FETCH.
  - !imem_busy && accept: fe_valid<=1, fe_instr<=rdata, fe_pc<=pc, pc<=pc+4.
  - !imem_busy && !accept: skid_instr<=rdata, skid_pc<=pc, pc<=pc+4, go to HOLD.
  - imem_busy: hold. If accept, fe_valid<=0 (a consumed latch empties).
- HOLD: imem_ren=0.
  - redirect: discard skid, pc<=redirect_pc, fe_valid<=0, go to FETCH.
  - !stall: fe_instr<=skid_instr, fe_pc<=skid_pc, fe_valid<=1, go to FETCH.
- SQUASH: imem_ren=1, imem_addr=old pc (the address is never changed mid-transaction). fe_valid=0.
  - A further redirect overwrites target_r.
  - !imem_busy: discard rdata, pc<=target_r (or redirect_pc if redirect in the same cycle), go to FETCH.
- Throughput: one instruction per cycle when imem_busy=0 and stall=0. Latency: the latch updates on the edge ending the completing bus cycle.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0. fe_pc4 wraps the same way.
- A simultaneous redirect and stall is resolved by redirect: the latch is invalidated regardless of stall.

Test Plan:
- Reset/straight-line: release nRST with busy=0, stall=0, rdata=addr^32'hA5A5_A5A5 -> imem_addr 0x200, 0x204, 0x208 on consecutive cycles; fe_pc follows one cycle later, fe_valid=1 from cycle 2, fe_pc4=fe_pc+4.
- Wait states: busy=1 for 3 cycles at 0x204 -> imem_addr held at 0x204, fe_valid=0 after 0x200 consumed, 0x204 latched on the first busy=0 cycle.
- Backpressure: stall=1 for 4 cycles while 0x208 completes -> state HOLD, imem_ren=0, fe_pc stays 0x204; stall drops -> fe_pc=0x208 next cycle, then fetch resumes at 0x20C.
- Redirect during busy: redirect to 0x1002 while 0x20C busy -> imem_addr stays 0x20C until busy=0, data dropped, next imem_addr=0x1000, no fe_valid with fe_pc=0x20C.
- Redirect in HOLD and in the same cycle as stall -> skid discarded, fe_valid=0 next cycle, next fetch at the target.
- Wrap and async reset: redirect to 0xFFFF_FFFC -> next fetch at 0x0, fe_pc4=0; assert nRST mid-busy -> all outputs return to reset values immediately, without waiting for a clock edge.
